// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue/stall controller: op codes, FSM encoding
// and op classification helpers.
package mdu_issue_ctrl_pkg;

  localparam int OP_W = 4;
  localparam int WD_W = 8;

  localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MDU_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] MDU_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] MDU_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] MDU_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BUSY  = 2'd2
  } state_e;

  function automatic logic is_mdu_op(input logic [OP_W-1:0] op);
    return (op != MDU_NONE) && (op <= MDU_MTLO);
  endfunction

  function automatic logic is_start(input logic [OP_W-1:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_watchdog.sv
// Loadable down-counter with a sticky error flag that tracks how long the MDU
// has been allowed to stay busy.
module mdu_watchdog
  import mdu_issue_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [WD_W-1:0] load_val,
  input  logic            dec,
  input  logic            err_set,
  output logic            last,
  output logic            err
);

  logic [WD_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (load)
        cnt <= load_val;
      else if (dec && (cnt != '0))
        cnt <= cnt - 1'b1;
      if (err_set)
        err <= 1'b1;
    end
  end

  // Asserted when the current decrement would exhaust the allowance.
  assign last = (cnt == {{(WD_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue/stall controller between the E-stage and the multiply/divide unit:
// gates requests, holds the pipeline while the MDU is busy, counts stalls.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_LAT  = 5,
  parameter int DIV_LAT  = 10,
  parameter int WD_SLACK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              flush,
  input  logic              mdu_busy,
  output logic [OP_W-1:0]   mdu_type,
  output logic [DATA_W-1:0] mdu_a,
  output logic [DATA_W-1:0] mdu_b,
  output logic              stall,
  output logic              wd_err,
  output logic [31:0]       stall_cnt
);

  localparam logic [WD_W-1:0] MUL_WD = WD_W'(MUL_LAT + WD_SLACK);
  localparam logic [WD_W-1:0] DIV_WD = WD_W'(DIV_LAT + WD_SLACK);

  state_e          state, state_nxt;
  logic            md_req, issue, start_issue;
  logic            wd_load, wd_dec, wd_err_set, wd_last;
  logic [WD_W-1:0] wd_load_val;

  // Every MDU op waits while anything is in flight: mf*/mt* touch HI/LO too.
  assign md_req      = req_valid & ~flush & is_mdu_op(req_op);
  assign stall       = md_req & ((state != IDLE) | mdu_busy);
  assign issue       = md_req & ~stall;
  assign start_issue = issue & is_start(req_op);

  assign mdu_type = issue ? req_op : MDU_NONE;
  assign mdu_a    = req_a;
  assign mdu_b    = req_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_issue) state_nxt = ARMED;
      ARMED:   state_nxt = mdu_busy ? BUSY : IDLE;
      BUSY:    if (!mdu_busy || wd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wd_load     = 1'b0;
    wd_dec      = 1'b0;
    wd_err_set  = 1'b0;
    wd_load_val = is_mul(req_op) ? MUL_WD : DIV_WD;
    case (state)
      IDLE:  wd_load = start_issue;
      ARMED: begin
        wd_dec     = mdu_busy;
        wd_err_set = ~mdu_busy;
      end
      BUSY: begin
        wd_dec     = mdu_busy;
        wd_err_set = mdu_busy & wd_last;
      end
      default: ;
    endcase
  end

  mdu_watchdog u_wd (
    .clk      (clk),
    .reset    (reset),
    .load     (wd_load),
    .load_val (wd_load_val),
    .dec      (wd_dec),
    .err_set  (wd_err_set),
    .last     (wd_last),
    .err      (wd_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a simple MDU stand-in and a
// cycle-level reference model of the issue/stall rules.
`timescale 1ns/1ps
module tb_mdu_issue_ctrl;

  localparam int MUL_LAT  = 5;
  localparam int DIV_LAT  = 10;
  localparam int WD_SLACK = 2;

  localparam int L_TYPE  = 0;
  localparam int L_STALL = 1;
  localparam int L_ERR   = 2;
  localparam int L_CNT   = 3;
  localparam int L_A     = 4;
  localparam int L_B     = 5;
  localparam int L_VAL   = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        flush = 1'b0;
  logic        mdu_busy;
  logic [3:0]  mdu_type;
  logic [31:0] mdu_a, mdu_b, stall_cnt;
  logic        stall, wd_err;

  int n_vec = 0;
  int n_bad = 0;

  logic        lit_en = 1'b0;
  int          lit_sel = 0;
  logic [31:0] lit_exp = 32'd0;
  logic [31:0] lit_act = 32'd0;
  string       lit_name = "";

  always #5 clk = ~clk;

  mdu_issue_ctrl #(
    .DATA_W(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .WD_SLACK(WD_SLACK)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush), .mdu_busy(mdu_busy),
    .mdu_type(mdu_type), .mdu_a(mdu_a), .mdu_b(mdu_b), .stall(stall),
    .wd_err(wd_err), .stall_cnt(stall_cnt)
  );

  // MDU stand-in: busy for the op latency starting the cycle after issue.
  logic stuck = 1'b0;
  int   mdu_left;
  always @(posedge clk or negedge reset) begin
    if (!reset)
      mdu_left <= 0;
    else if (mdu_type == 4'd1 || mdu_type == 4'd2)
      mdu_left <= MUL_LAT;
    else if (mdu_type == 4'd3 || mdu_type == 4'd4)
      mdu_left <= DIV_LAT;
    else if (mdu_left != 0)
      mdu_left <= mdu_left - 1;
  end
  assign mdu_busy = (mdu_left != 0) | stuck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: "in flight" from the cycle after a start-op issue until
  // busy drops, busy never appears, or busy has lasted latency+slack cycles.
  bit          m_idle = 1'b1;
  bit          m_armed = 1'b0;
  bit          m_err = 1'b0;
  int          m_seen = 0;
  int          m_limit = 0;
  logic [31:0] m_cnt = 32'd0;
  logic        e_req, e_stall;
  logic [3:0]  e_type;
  logic [31:0] l_act;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      m_idle = 1'b1; m_armed = 1'b0; m_err = 1'b0; m_seen = 0; m_cnt = 32'd0;
    end else begin
      e_req   = req_valid && !flush && (req_op >= 4'd1) && (req_op <= 4'd8);
      e_stall = e_req && (!m_idle || mdu_busy);
      e_type  = (e_req && !e_stall) ? req_op : 4'd0;
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mdu_type", 32'(mdu_type), 32'(e_type));
      chk("mdu_a", mdu_a, req_a);
      chk("mdu_b", mdu_b, req_b);
      chk("wd_err", 32'(wd_err), 32'(m_err));
      chk("stall_cnt", stall_cnt, m_cnt);
      if (lit_en) begin
        case (lit_sel)
          L_TYPE:  l_act = 32'(mdu_type);
          L_STALL: l_act = 32'(stall);
          L_ERR:   l_act = 32'(wd_err);
          L_CNT:   l_act = stall_cnt;
          L_A:     l_act = mdu_a;
          L_B:     l_act = mdu_b;
          default: l_act = lit_act;
        endcase
        chk(lit_name, l_act, lit_exp);
      end
      if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_idle) begin
        if (e_type >= 4'd1 && e_type <= 4'd4) begin
          m_idle  = 1'b0;
          m_armed = 1'b1;
          m_seen  = 0;
          m_limit = ((e_type <= 4'd2) ? MUL_LAT : DIV_LAT) + WD_SLACK;
        end
      end else if (!mdu_busy) begin
        if (m_armed) m_err = 1'b1;
        m_idle  = 1'b1;
        m_armed = 1'b0;
      end else begin
        m_armed = 1'b0;
        m_seen++;
        if (m_seen >= m_limit) begin
          m_err  = 1'b1;
          m_idle = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    req_valid = v; req_op = op; req_a = a; req_b = b; flush = fl;
  endtask

  task automatic expect_lit(input int sel, input logic [31:0] exp, input string nm,
                            input logic [31:0] act);
    lit_sel = sel; lit_exp = exp; lit_name = nm; lit_act = act; lit_en = 1'b1;
  endtask

  // Counts stalled cycles of the current request; returns at the negedge of
  // the cycle it issues (or after the cycle budget runs out).
  task automatic wait_issue(output int nst, output logic [3:0] ty);
    bit done;
    done = 1'b0; nst = 0; ty = 4'd0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        ty = mdu_type;
      end else begin
        nst++;
        step();
      end
    end
  endtask

  int         nst;
  logic [3:0] ty;

  initial begin
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset in the middle of a mult with a stalled mflo behind it.
    drive(1'b1, 4'd1, 32'd7, 32'd9, 1'b0);
    step(); drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    step(); step();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    expect_lit(L_CNT, 32'd0, "rst_stall_cnt", 32'd0);
    step(); expect_lit(L_ERR, 32'd0, "rst_wd_err", 32'd0);
    step(); expect_lit(L_TYPE, 32'd0, "rst_type_idle", 32'd0);
    step(); drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    expect_lit(L_TYPE, 32'd6, "rst_mflo_no_wait", 32'd0);

    // mult followed by a dependent mflo.
    step(); drive(1'b1, 4'd1, 32'd3, 32'hFFFF_FFFE, 1'b0);
    expect_lit(L_TYPE, 32'd1, "mult_issue", 32'd0);
    step(); drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    wait_issue(nst, ty);
    step(); drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    expect_lit(L_VAL, 32'd6, "mflo_stall_cycles", 32'(nst));
    step(); expect_lit(L_VAL, 32'd6, "mflo_issue_type", 32'(ty));
    step(); expect_lit(L_CNT, 32'd6, "stall_cnt_after_mflo", 32'd0);

    // div followed by divu.
    step(); drive(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
    expect_lit(L_TYPE, 32'd3, "div_issue", 32'd0);
    step(); drive(1'b1, 4'd4, 32'd5, 32'd6, 1'b0);
    wait_issue(nst, ty);
    step(); expect_lit(L_TYPE, 32'd0, "divu_once", 32'd0);
    step(); drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    expect_lit(L_VAL, 32'd11, "divu_stall_cycles", 32'(nst));
    step(); expect_lit(L_VAL, 32'd4, "divu_issue_type", 32'(ty));
    repeat (14) step();

    // flush suppresses issue and stall; FSM stays idle.
    drive(1'b1, 4'd1, 32'd1, 32'd2, 1'b1);
    expect_lit(L_TYPE, 32'd0, "flush_no_issue", 32'd0);
    step(); drive(1'b1, 4'd1, 32'd1, 32'd2, 1'b0);
    expect_lit(L_TYPE, 32'd1, "mult_after_flush", 32'd0);
    step(); drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b1);
    expect_lit(L_STALL, 32'd0, "flush_no_stall", 32'd0);
    step(); drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    expect_lit(L_STALL, 32'd1, "mflo_waits_after_flush", 32'd0);
    step(); drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    repeat (8) step();

    // MDU busy stuck high after a multu: watchdog fires and sticks.
    drive(1'b1, 4'd2, 32'd4, 32'd4, 1'b0);
    expect_lit(L_TYPE, 32'd2, "wd_multu_issue", 32'd0);
    step(); stuck = 1'b1; drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    repeat (5) step();
    step(); expect_lit(L_ERR, 32'd0, "wd_quiet_at_limit", 32'd0);
    step(); expect_lit(L_ERR, 32'd1, "wd_fires", 32'd0);
    step(); drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
    expect_lit(L_STALL, 32'd1, "wd_stall_tracks_busy", 32'd0);
    step(); stuck = 1'b0;
    drive(1'b1, 4'd7, 32'h0000_A5A5, 32'd0, 1'b0);
    expect_lit(L_TYPE, 32'd7, "mthi_issue", 32'd0);
    step(); drive(1'b1, 4'd8, 32'h0000_5A5A, 32'd0, 1'b0);
    expect_lit(L_TYPE, 32'd8, "mtlo_back_to_back", 32'd0);
    step(); drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    expect_lit(L_ERR, 32'd1, "wd_sticky", 32'd0);
    step(); drive(1'b0, 4'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFE, 1'b0);
    expect_lit(L_A, 32'hDEAD_BEEF, "mdu_a_passthrough", 32'd0);
    step(); expect_lit(L_B, 32'hFFFF_FFFE, "mdu_b_passthrough", 32'd0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
